// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider.
package div_pkg;

  // Default operand width: divisor, quotient and remainder are N bits, dividend 2N bits.
  localparam int DIV_N = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHECK = 2'd1,
    S_ITER  = 2'd2,
    S_DONE  = 2'd3
  } div_state_e;

endpackage

// File: rtl/div_control.sv
// Divider sequencer: FSM plus iteration counter. Produces Load/Sh/Sub/Done
// strobes for the datapath in the same split as the shift-and-add multiplier.
module div_control
  import div_pkg::*;
#(
  parameter int N = DIV_N
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_st,      // start request, honoured only in IDLE
  input  logic i_ovf,     // upper dividend half >= divisor (includes divisor 0)
  input  logic i_ge,      // shifted partial remainder >= divisor
  output logic o_load,    // capture operands, clear V and counter
  output logic o_sh,      // one shift step this cycle
  output logic o_sub,     // subtract and set quotient bit this cycle
  output logic o_set_v,   // flag overflow
  output logic o_last,    // final iteration: latch results
  output logic o_done,
  output logic o_busy
);

  localparam int CW = $clog2(N) + 1;

  div_state_e r_state;
  div_state_e w_state_next;
  logic [CW-1:0] r_cnt;
  logic w_tc;

  assign w_tc   = (r_cnt == CW'(N - 1));
  assign o_sub  = o_sh & i_ge;
  assign o_last = o_sh & w_tc;
  assign o_done = (r_state == S_DONE);
  assign o_busy = (r_state != S_IDLE);

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_next;
  end

  // Iteration counter: cleared on accept, advances once per ITER cycle.
  always_ff @(posedge i_clk) begin
    if (i_reset)           r_cnt <= '0;
    else if (o_load)       r_cnt <= '0;
    else if (o_sh)         r_cnt <= r_cnt + CW'(1);
  end

  // Next-state and strobe decode.
  always_comb begin
    w_state_next = r_state;
    o_load       = 1'b0;
    o_sh         = 1'b0;
    o_set_v      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_st) begin
          o_load       = 1'b1;
          w_state_next = S_CHECK;
        end
      end
      S_CHECK: begin
        if (i_ovf) begin
          o_set_v      = 1'b1;
          w_state_next = S_DONE;
        end else begin
          w_state_next = S_ITER;
        end
      end
      S_ITER: begin
        o_sh = 1'b1;
        if (w_tc) w_state_next = S_DONE;
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

endmodule

// File: rtl/div_unit.sv
// Sequential restoring divider, 2N/N -> N quotient + N remainder, one
// shift/subtract step per clock. Overflow (incl. divide by zero) is caught
// before iterating and leaves the previous results in place.
module div_unit
  import div_pkg::*;
#(
  parameter int N = DIV_N
) (
  input  logic           i_clk,
  input  logic           i_reset,
  input  logic           i_st,
  input  logic [2*N-1:0] i_dividend,
  input  logic [N-1:0]   i_divisor,
  output logic [N-1:0]   o_quotient,
  output logic [N-1:0]   o_remainder,
  output logic           o_v,
  output logic           o_busy,
  output logic           o_done
);

  logic [2*N:0]   r_acc;
  logic [N-1:0]   r_div;
  logic [N-1:0]   r_quot;
  logic [N-1:0]   r_rem;
  logic           r_v;

  logic [2*N:0]   w_shift;
  logic [N:0]     w_upper;
  logic [N:0]     w_diff;
  logic [2*N:0]   w_acc_iter;
  logic           w_ge;
  logic           w_ovf;
  logic           w_load;
  logic           w_sh;
  logic           w_sub;
  logic           w_set_v;
  logic           w_last;

  // Compare is done on the shifted value in the same cycle, so a failed
  // trial never needs a restore step.
  assign w_shift    = r_acc << 1;
  assign w_upper    = w_shift[2*N:N];
  assign w_ge       = (w_upper >= {1'b0, r_div});
  assign w_diff     = w_upper - {1'b0, r_div};
  assign w_acc_iter = w_sub ? {w_diff, w_shift[N-1:1], 1'b1} : w_shift;
  assign w_ovf      = (r_acc[2*N-1:N] >= r_div);

  assign o_quotient  = r_quot;
  assign o_remainder = r_rem;
  assign o_v         = r_v;

  div_control #(.N(N)) u_ctrl (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_st    (i_st),
    .i_ovf   (w_ovf),
    .i_ge    (w_ge),
    .o_load  (w_load),
    .o_sh    (w_sh),
    .o_sub   (w_sub),
    .o_set_v (w_set_v),
    .o_last  (w_last),
    .o_done  (o_done),
    .o_busy  (o_busy)
  );

  // Accumulator and divisor: load on accept, step during ITER.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_acc <= '0;
      r_div <= '0;
    end else if (w_load) begin
      r_acc <= {1'b0, i_dividend};
      r_div <= i_divisor;
    end else if (w_sh) begin
      r_acc <= w_acc_iter;
    end
  end

  // Overflow flag: cleared on accept, set from the pre-iteration check.
  always_ff @(posedge i_clk) begin
    if (i_reset)      r_v <= 1'b0;
    else if (w_load)  r_v <= 1'b0;
    else if (w_set_v) r_v <= 1'b1;
  end

  // Result registers update only on the final step, so they hold across
  // overflow runs and while the next division iterates.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_quot <= '0;
      r_rem  <= '0;
    end else if (w_last) begin
      r_quot <= w_acc_iter[N-1:0];
      r_rem  <= w_acc_iter[2*N-1:N];
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: stimulus pushes expected results, a monitor
// pops and compares on every Done pulse.
module tb_div_unit;

  localparam int N = 8;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           st = 1'b0;
  logic [2*N-1:0] dividend = '0;
  logic [N-1:0]   divisor = '0;
  logic [N-1:0]   quotient;
  logic [N-1:0]   remainder;
  logic           v;
  logic           busy;
  logic           done;

  div_unit #(.N(N)) dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_st        (st),
    .i_dividend  (dividend),
    .i_divisor   (divisor),
    .o_quotient  (quotient),
    .o_remainder (remainder),
    .o_v         (v),
    .o_busy      (busy),
    .o_done      (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int q;
    int r;
    int v;
    int cyc;
    int dvd;
    int dsr;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   last_q = 0;
  int   last_r = 0;
  bit   chk_busy_low = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: plain integer division with the overflow rule applied first.
  function automatic exp_t model(input int dvd, input int dsr);
    exp_t e;
    e.dvd = dvd;
    e.dsr = dsr;
    if (dsr == 0 || (dvd / 256) >= dsr) begin
      e.v = 1; e.q = last_q; e.r = last_r;
    end else begin
      e.v = 0; e.q = dvd / dsr; e.r = dvd % dsr;
      last_q = e.q; last_r = e.r;
    end
    e.cyc = 0;
    return e;
  endfunction

  // Monitor: compare every Done pulse against the oldest expectation.
  always @(negedge clk) begin
    if (chk_busy_low) begin
      check("busy_after_done", int'(busy), 0);
      chk_busy_low = 1'b0;
    end
    if (done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        $display("div %0d / %0d -> q=%0d r=%0d v=%0d at cycle %0d", e.dvd, e.dsr,
                 quotient, remainder, v, cyc);
        check("quotient", int'(quotient), e.q);
        check("remainder", int'(remainder), e.r);
        check("overflow_v", int'(v), e.v);
        check("done_cycle", cyc, e.cyc);
        check("busy_in_done", int'(busy), 1);
        chk_busy_low = 1'b1;
      end
    end
  end

  task automatic check_zero_outputs(input string tag);
    check({tag, "_quotient"}, int'(quotient), 0);
    check({tag, "_remainder"}, int'(remainder), 0);
    check({tag, "_v"}, int'(v), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    sb.delete();
    last_q = 0;
    last_r = 0;
    repeat (cycles) @(negedge clk);
    chk_busy_low = 1'b0;
    check_zero_outputs("reset");
    reset = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("wait_idle_timeout", 1, 0);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() > 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_pending", sb.size(), 0);
  endtask

  // Issue one division from IDLE; returns 1ns after the accepting edge.
  task automatic start_div(input int dvd, input int dsr);
    exp_t e;
    wait_idle();
    st = 1'b1;
    dividend = 16'(dvd);
    divisor = 8'(dsr);
    e = model(dvd, dsr);
    @(posedge clk);
    #1;
    st = 1'b0;
    dividend = 16'($urandom);
    divisor = 8'($urandom);
    e.cyc = cyc + ((e.v != 0) ? 1 : N + 1);
    sb.push_back(e);
  endtask

  initial begin
    int e0;
    #2000000;
    $display("FAIL global_timeout actual=%0d required=0", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int dvd, dsr, e0, mode;
    exp_t e;

    do_reset(2);
    repeat (5) @(negedge clk);
    check_zero_outputs("idle_hold");

    start_div(1000, 37);
    start_div(16'hFEFF, 8'hFF);
    start_div(16'h00FF, 1);
    start_div(16'h1234, 8'h12);
    start_div(16'hABCD, 0);
    drain();

    // St pulse mid-iteration must be ignored.
    start_div(5000, 77);
    repeat (4) @(negedge clk);
    st = 1'b1;
    dividend = 16'd300;
    divisor = 8'd9;
    @(negedge clk);
    st = 1'b0;
    drain();

    // St held high: back-to-back accepts every N+3 cycles.
    wait_idle();
    st = 1'b1;
    dividend = 16'd4321;
    divisor = 8'd55;
    e = model(4321, 55);
    @(posedge clk);
    #1;
    e0 = cyc;
    for (int k = 0; k < 3; k++) begin
      e.cyc = e0 + N + 1 + k * (N + 3);
      sb.push_back(e);
    end
    repeat (2 * (N + 3) + 4) @(posedge clk);
    #1;
    st = 1'b0;
    drain();

    // Reset during the 4th ITER cycle: no Done, everything back to 0.
    start_div(60000, 250);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    sb.delete();
    last_q = 0;
    last_r = 0;
    @(negedge clk);
    check_zero_outputs("midreset");
    reset = 1'b0;
    repeat (12) @(negedge clk);
    start_div(100, 7);
    drain();

    // Randomized divisions, mostly in range with some overflow/zero cases.
    for (int i = 0; i < 40; i++) begin
      mode = $urandom_range(0, 9);
      dsr = $urandom_range(0, 255);
      if (mode == 0) dsr = 0;
      if (mode <= 1 || dsr == 0) dvd = $urandom_range(0, 65535);
      else dvd = $urandom_range(0, dsr - 1) * 256 + $urandom_range(0, 255);
      start_div(dvd, dsr);
    end
    drain();
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
